pulse_period_meter: RTL and testbench
=====================================

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter CLK_PER_US, default 20, SHALL be the number of clk cycles per microsecond (20 MHz clock).
REQ-003 Parameter CNT_W, default 16, SHALL be the width of all measurement counters and outputs.
REQ-004 Port clk  input  1  system clock, rising-edge active.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port en  input  1  measurement enable; low forces IDLE.
REQ-007 Port pulse_in  input  1  pulse train under test (e.g. the 1 us / 3 us tick from the counter modules).
REQ-008 Port period_cyc  output  CNT_W  clk cycles between the last two pulse_in rising edges.
REQ-009 Port period_us  output  CNT_W  floor(period_cyc / CLK_PER_US).
REQ-010 Port width_cyc  output  CNT_W  clk cycles pulse_in was high within the measured period.
REQ-011 Port valid  output  1  one-cycle strobe; outputs updated this cycle.
REQ-012 Port overflow  output  1  sticky flag; period exceeded 2^CNT_W-1 cycles.
REQ-013 Port busy  output  1  high in states ARMED and MEASURE.

Function
REQ-014 pulse_in SHALL pass through a 2-flop synchronizer; rise = sync & ~sync_d, fall = ~sync & sync_d.
REQ-015 FSM states SHALL be IDLE, ARMED, MEASURE.
REQ-016 IDLE -> ARMED when en=1; any state -> IDLE when en=0, with counters cleared and outputs holding their last values.
REQ-017 ARMED -> MEASURE on rise; cyc_cnt loads 1, pre_cnt loads 1, us_cnt loads 0, hi_cnt loads 1.
REQ-018 In MEASURE, cyc_cnt SHALL increment by 1 per cycle; pre_cnt SHALL count 1..CLK_PER_US-1 and, when incrementing from CLK_PER_US-1, wrap to 0 and increment us_cnt (no divider).
REQ-019 In MEASURE, hi_cnt SHALL increment each cycle sync=1 until the first fall after the starting rise, then freeze.
REQ-020 On rise in MEASURE: period_cyc <= cyc_cnt, period_us <= us_cnt, width_cyc <= hi_cnt, valid <= 1, overflow <= 0; counters reload per REQ-017; state stays MEASURE.
REQ-021 A pulse_in train with one rise every N clk cycles SHALL yield period_cyc = N.
REQ-022 If cyc_cnt = 2^CNT_W-1 in MEASURE without a rise: overflow <= 1, no valid, state -> ARMED.
REQ-023 A rise in the same cycle as en falling SHALL be ignored (IDLE takes priority).
REQ-024 valid SHALL rise on the second clk edge after the edge at which pulse_in is first sampled high, and last exactly one cycle.
REQ-025 pulse_in high continuously SHALL produce no rise after the first; overflow then follows per REQ-022.

Reset
REQ-026 On rst_n=0: state IDLE; synchronizer flops 0; all counters 0; period_cyc, period_us, width_cyc 0; valid, overflow, busy 0.
REQ-027 Reset asserted mid-measurement SHALL abort immediately; after release, the first valid requires two fresh rises.

Structure
REQ-028 Package pulse_meter_pkg SHALL hold the FSM state enum and default CLK_PER_US / CNT_W constants.
REQ-029 Sub-module edge_sync (2-flop synchronizer plus rise/fall detect) SHALL be instantiated once.

Verification
REQ-030 en=1; 1-cycle pulses every 20 clk (1 us tick) -> from the 2nd rise on, valid every 20 cycles with period_cyc=20, period_us=1, width_cyc=1.
REQ-031 Pulses every 60 clk, 5 cycles high -> period_cyc=60, period_us=3, width_cyc=5.
REQ-032 CNT_W=8; one rise, then none for 300 cycles -> overflow=1 after 255 cycles in MEASURE, no valid, busy=1; the next two rises 40 apart -> valid, period_cyc=40, overflow=0.
REQ-033 en dropped 10 cycles after a rise -> busy=0 next cycle, no valid, outputs hold; en re-raised -> first valid only after two new rises.
REQ-034 rst_n pulsed low mid-period -> all outputs 0 asynchronously; measurement restarts per REQ-027.
REQ-035 valid latency: pulse_in rises just before edge k -> valid high between edges k+2 and k+3 only.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and default parameters for the pulse period meter.
package pulse_meter_pkg;

  localparam int CLK_PER_US_DEF = 20;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus registered-edge detect.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period (cycles and microseconds) and high width of a pulse train
// between consecutive synchronized rising edges.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period_cyc,
  output logic [CNT_W-1:0] period_us,
  output logic [CNT_W-1:0] width_cyc,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int PRE_W = $clog2(CLK_PER_US + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic sync, rise, fall;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pulse_in),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  meter_state_e state_q, state_d;
  logic [CNT_W-1:0] cyc_cnt, us_cnt, hi_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic             hi_frozen;
  logic             start, capture, ovf_hit;

  // en low wins over everything, including a coincident rise.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    ovf_hit = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED: begin
          if (rise) begin
            state_d = MEASURE;
            start   = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            capture = 1'b1;
            start   = 1'b1;
          end else if (cyc_cnt == CNT_MAX) begin
            ovf_hit = 1'b1;
            state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prescaler runs alongside cyc_cnt so period_us needs no divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      pre_cnt   <= '0;
      us_cnt    <= '0;
      hi_cnt    <= '0;
      hi_frozen <= 1'b0;
    end else if (start) begin
      cyc_cnt   <= CNT_ONE;
      pre_cnt   <= PRE_ONE;
      us_cnt    <= '0;
      hi_cnt    <= CNT_ONE;
      hi_frozen <= 1'b0;
    end else if (state_d != MEASURE) begin
      cyc_cnt   <= '0;
      pre_cnt   <= '0;
      us_cnt    <= '0;
      hi_cnt    <= '0;
      hi_frozen <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_ONE;
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        us_cnt  <= us_cnt + CNT_ONE;
      end else begin
        pre_cnt <= pre_cnt + PRE_ONE;
      end
      if (fall) begin
        hi_frozen <= 1'b1;
      end else if (sync && !hi_frozen) begin
        hi_cnt <= hi_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cyc <= '0;
      period_us  <= '0;
      width_cyc  <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        period_cyc <= cyc_cnt;
        period_us  <= us_cnt;
        width_cyc  <= hi_cnt;
        overflow   <= 1'b0;
      end else if (ovf_hit) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomized scoreboard bench for pulse_period_meter; reference model tracks
// counted rising edges by edge index and derives period/width arithmetically.
module tb_pulse_period_meter;

  localparam int CPU  = 20;
  localparam int W    = 8;
  localparam int MAXC = (1 << W) - 1;
  localparam int NH   = 32768;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         en       = 1'b0;
  logic         pulse_in = 1'b0;
  logic [W-1:0] period_cyc, period_us, width_cyc;
  logic         valid, overflow, busy;

  pulse_period_meter #(.CLK_PER_US(CPU), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pulse_in   (pulse_in),
    .period_cyc (period_cyc),
    .period_us  (period_us),
    .width_cyc  (width_cyc),
    .valid      (valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int per;
    int us;
    int wid;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: edge index k, first post-reset edge k0, input history per edge.
  int   k = 0;
  int   k0 = 0;
  bit   in_reset = 1'b1;
  bit   ph [NH];
  bit   eh [NH];
  bit   have_r = 1'b0;
  int   r = 0;
  bit   exp_ovf = 1'b0;
  bit   exp_busy = 1'b0;
  int   exp_per = 0, exp_us = 0, exp_wid = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse / enable value sampled at edge j; nothing before reset release counts.
  function automatic bit pv(int j);
    return (j < k0) ? 1'b0 : ph[j];
  endfunction

  function automatic bit ev(int j);
    return (j < k0) ? 1'b0 : eh[j];
  endfunction

  initial begin : model
    bit rise;
    int w;
    int per;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        in_reset = 1'b1;
        sbq.delete();
        have_r   = 1'b0;
        exp_ovf  = 1'b0;
        exp_busy = 1'b0;
        exp_per  = 0;
        exp_us   = 0;
        exp_wid  = 0;
      end else begin
        if (in_reset) begin
          k0 = k;
          in_reset = 1'b0;
        end
        ph[k] = pulse_in;
        eh[k] = en;
        // A pulse seen at edge j becomes an edge decision two edges later.
        rise = pv(k - 2) && !pv(k - 3);
        if (!en) begin
          have_r = 1'b0;
        end else if (ev(k - 1)) begin
          if (rise) begin
            if (have_r) begin
              per = k - r;
              w = 0;
              for (int j = r; j < k && pv(j - 2); j++) w++;
              sbq.push_back('{k, per, per / CPU, w});
              exp_per = per;
              exp_us  = per / CPU;
              exp_wid = w;
              exp_ovf = 1'b0;
            end
            have_r = 1'b1;
            r = k;
          end else if (have_r && (k - r) == MAXC) begin
            exp_ovf = 1'b1;
            have_r  = 1'b0;
          end
        end
        exp_busy = en;
        k++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("valid_edge", k - 1, e.tag);
            chk("sb_period_cyc", int'(period_cyc), e.per);
            chk("sb_period_us", int'(period_us), e.us);
            chk("sb_width_cyc", int'(width_cyc), e.wid);
          end
        end else if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("missed_valid", 0, 1);
        end
        chk("busy", int'(busy), int'(exp_busy));
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("hold_period_cyc", int'(period_cyc), exp_per);
        chk("hold_period_us", int'(period_us), exp_us);
        chk("hold_width_cyc", int'(width_cyc), exp_wid);
      end
    end
  end

  task automatic step(input bit p);
    @(negedge clk);
    pulse_in = p;
  endtask

  task automatic train(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++) step(j < hi);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period_cyc"}, int'(period_cyc), 0);
    chk({tag, "_period_us"}, int'(period_us), 0);
    chk({tag, "_width_cyc"}, int'(width_cyc), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin : stim
    int per_r, hi_r, ph_i;
    repeat (4) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) step(1'b0);

    train(20, 1, 6);                 // 1 us tick
    train(60, 5, 4);                 // 3 us tick, 5 cycles high
    step(1'b1);                      // lone rise then silence -> overflow
    repeat (300) step(1'b0);
    train(40, 1, 4);
    repeat (300) step(1'b1);         // stuck high: one rise only
    step(1'b0);
    train(20, 1, 3);

    train(30, 2, 3);                 // en drop 10 cycles after a rise
    step(1'b1);
    repeat (9) step(1'b0);
    en = 1'b0;
    train(20, 1, 3);
    en = 1'b1;
    train(25, 3, 4);

    train(50, 4, 2);                 // async reset mid-period
    repeat (20) step(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    train(35, 2, 4);

    per_r = 20;
    hi_r  = 1;
    ph_i  = 0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      step(ph_i < hi_r);
      ph_i++;
      if (ph_i >= per_r) begin
        ph_i = 0;
        if ($urandom_range(0, 3) == 0) begin
          per_r = $urandom_range(2, 250);
          hi_r  = $urandom_range(1, per_r - 1);
          if ($urandom_range(0, 15) == 0) begin
            per_r = $urandom_range(256, 320);
            hi_r  = ($urandom_range(0, 1) == 0) ? per_r : 1;
          end
        end
      end
    end
    en = 1'b1;
    repeat (20) step(1'b0);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
